compare_pipe: RTL and testbench
===============================

# compare_pipe

Parametrised, pipelined successor to the combinational CLA + ZVN + compare_unit chain. It computes `a − b` and derives the Z/V/N/C flags. It then resolves one of four compare modes, signed and unsigned, into a WIDTH-bit boolean result. The path is two registered stages with a valid/ready handshake, so it can sit directly on the ALU result bus of the pipelined datapath without lengthening the critical path.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width (≥ 2).
- `REG_OUT_FLAGS`, default 1: when 1, `z/v/n/c` are exported; when 0, those ports are tied to 0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand.
- `cmp_fn`  in  2  compare mode:
  - 00 = CMPLTU
  - 01 = CMPEQ
  - 10 = CMPLT
  - 11 = CMPLE
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  `{WIDTH-1 zeros, cmp_bit}`.
- `z`, `v`, `n`, `c`  out  1 each  flags of `a − b` for the beat on `result`.

## Operation
- Subtraction is `a + ~b + 1` with carry-in forced to 1, always; there is no add mode.
  - `s` = WIDTH-bit sum; `c` = carry-out.
- Flags:
  - `z` = (`s` == 0).
  - `n` = `s[WIDTH-1]`.
  - `v` = (`a[MSB]` ≠ `b[MSB]`) & (`s[MSB]` ≠ `a[MSB]`).
  - `c` = carry-out, which is 1 when `a` ≥ `b` unsigned.
- `cmp_bit` by mode:
  - CMPEQ = `z`.
  - CMPLT = `n ^ v`.
  - CMPLE = `z | (n ^ v)`.
  - CMPLTU = `~c`.
- Stage 1 (S1) registers `a`, `b` and `cmp_fn` together with valid bit `s1_v`.
- Stage 2 (S2) registers the adder output, flags and `cmp_bit`, with `s2_v`. `out_valid` = `s2_v`.
- Flow control:
  - `s2_adv` = `~s2_v | out_ready`.
  - `s1_adv` = `~s1_v | s2_adv`.
  - `in_ready` = `s1_adv`.
  - Stages advance only when their `adv` term is true; otherwise they hold contents bit-exact.
- Stage updates:
  - S1 loads when `in_valid & in_ready`.
  - S1 clears `s1_v` when it advances without a new beat.
  - S2 loads from S1 when `s2_adv`, and takes `s2_v` = `s1_v`.
- No beat is dropped or duplicated; beats leave in order.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - `s1_v` = `s2_v` = 0, so `out_valid` = 0.
  - `result` = 0 and `z/v/n/c` = 0.
  - `in_ready` = 1 from the first cycle after release.
- Latency: a beat accepted at edge k appears on `out_valid`/`result` after edge k+1, i.e. 2 cycles, when `out_ready` is held high.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- Stall: with `out_ready` = 0 and both stages full, `in_ready` = 0 combinationally in the same cycle.
  - Capacity is 2 beats.
  - `result` and flags stay stable while `out_valid & ~out_ready`.
- Simultaneous events:
  - Accept and emit in one cycle on a full pipe is legal when `out_ready` = 1.
  - `in_ready` depends on `out_ready` combinationally; this is the only combinational input→output path.
- Reset mid-stream discards both stages immediately. Any beat whose `in_valid` was high during reset is not captured.
- Boundary values: `a` = `b` gives `z` = 1 and `c` = 1. Most-negative minus positive sets `v` = 1 and CMPLT still resolves correctly.

## Structure
- Shared package `cmp_pkg`: `CMP_LTU`/`CMP_EQ`/`CMP_LT`/`CMP_LE` 2-bit localparams, and a `cmp_decode` function (flags + fn → bit).
- Reuse existing `carry_lookahead_adder #(WIDTH)` and `zvn #(WIDTH)` in S2's combinational input; do not duplicate them.
- One new sub-module is natural: `pipe_stage_ctl`, holding the valid/advance logic for one stage and instantiated twice.

## Test plan
- Reset then idle: `in_ready` = 1, `out_valid` = 0, `result` = 0 → release reset with `in_valid` = 0 for 5 cycles; nothing emitted.
- `a`=0x0101, `b`=0x0011, CMPLT → after 2 cycles `result`=0x0000, `z`=0, `n`=0, `v`=0, `c`=1.
- `a`=0xFFFF, `b`=0x0001 → CMPLT `result`=0x0001; CMPLTU `result`=0x0000, `c`=1; CMPEQ `result`=0x0000.
- `a`=0xC0FF, `b`=0xEECC → CMPLE `result`=0x0001. Then `a`=0x8000, `b`=0x0001 with CMPLT → `v`=1, `n`=0, `result`=0x0001. Then `a`=`b`=0xA234 with CMPLE → `z`=1, `result`=0x0001.
- Back-to-back 4 beats with `out_ready` low for 3 cycles mid-stream:
  - `in_ready` drops after 2 beats are held.
  - `result` is stable while stalled.
  - All 4 results emerge in order with no loss or duplication.
- Assert `rst_n` low while both stages are full → `out_valid` = 0 asynchronously; after release the first new beat emerges after 2 cycles.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared compare-mode encodings, flag bundle and the flags+mode -> boolean decode.
package cmp_pkg;

  localparam logic [1:0] CMP_LTU = 2'b00;
  localparam logic [1:0] CMP_EQ  = 2'b01;
  localparam logic [1:0] CMP_LT  = 2'b10;
  localparam logic [1:0] CMP_LE  = 2'b11;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic c;
  } flags_t;

  function automatic logic cmp_decode(input flags_t f, input logic [1:0] fn);
    logic cmp_bit;
    case (fn)
      CMP_EQ:  cmp_bit = f.z;
      CMP_LT:  cmp_bit = f.n ^ f.v;
      CMP_LE:  cmp_bit = f.z | (f.n ^ f.v);
      default: cmp_bit = ~f.c;
    endcase
    return cmp_bit;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Generate/propagate adder: sum = a + b + cin, with carry-out.
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   carry;

  assign g = a & b;
  assign p = a ^ b;

  // NOTE: carry[0] is written before the loop and every later bit inside it,
  // so each bit is assigned on every evaluation and no latch can be inferred.
  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = g[i] | (p[i] & carry[i]);
    end
  end

  assign sum  = p ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

endmodule

// File: rtl/pipe_stage_ctl.sv
// Valid bit and advance/load terms for one elastic pipeline stage.
module pipe_stage_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic up_valid,
  input  logic down_ready,
  output logic valid,
  output logic adv,
  output logic load
);

  assign adv  = ~valid | down_ready;
  assign load = adv & up_valid;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
    end
  end

endmodule

// File: rtl/zvn.sv
// Zero / signed-overflow / negative flags of a subtraction result a - b.
module zvn #(
  parameter int WIDTH = 16
) (
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [WIDTH-1:0] sum,
  output logic             z,
  output logic             v,
  output logic             n
);

  assign z = (sum == '0);
  assign n = sum[WIDTH-1];
  // Overflow only when operand signs differ and the result sign left a's sign.
  assign v = (a_msb != b_msb) && (sum[WIDTH-1] != a_msb);

endmodule

// File: rtl/compare_pipe.sv
// Two-stage pipelined a - b with Z/V/N/C flags and a four-mode compare result.
module compare_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter bit REG_OUT_FLAGS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       cmp_fn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c
);

  logic s1_v, s1_adv, s1_load;
  logic s2_v, s2_adv, s2_load;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_fn;

  logic [WIDTH-1:0] diff;
  logic             carry_out;
  flags_t           s2_in_flags;
  logic             s2_in_cmp;

  flags_t           s2_flags;
  logic             s2_cmp;

  pipe_stage_ctl u_s1_ctl (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (in_valid),
    .down_ready (s2_adv),
    .valid      (s1_v),
    .adv        (s1_adv),
    .load       (s1_load)
  );

  pipe_stage_ctl u_s2_ctl (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (s1_v),
    .down_ready (out_ready),
    .valid      (s2_v),
    .adv        (s2_adv),
    .load       (s2_load)
  );

  assign in_ready  = s1_adv;
  assign out_valid = s2_v;

  // NOTE: payload registers are reset as well, because result and flags must
  // read as zero out of reset, not just be qualified by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a  <= '0;
      s1_b  <= '0;
      s1_fn <= CMP_LTU;
    end else if (s1_load) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_fn <= cmp_fn;
    end
  end

  // Subtraction only: invert b and force the carry-in high.
  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (s1_a),
    .b    (~s1_b),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry_out)
  );

  zvn #(.WIDTH(WIDTH)) u_zvn (
    .a_msb (s1_a[WIDTH-1]),
    .b_msb (s1_b[WIDTH-1]),
    .sum   (diff),
    .z     (s2_in_flags.z),
    .v     (s2_in_flags.v),
    .n     (s2_in_flags.n)
  );

  assign s2_in_flags.c = carry_out;
  assign s2_in_cmp     = cmp_decode(s2_in_flags, s1_fn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_flags <= '0;
      s2_cmp   <= 1'b0;
    end else if (s2_load) begin
      s2_flags <= s2_in_flags;
      s2_cmp   <= s2_in_cmp;
    end
  end

  assign result = {{(WIDTH-1){1'b0}}, s2_cmp};
  assign z      = REG_OUT_FLAGS ? s2_flags.z : 1'b0;
  assign v      = REG_OUT_FLAGS ? s2_flags.v : 1'b0;
  assign n      = REG_OUT_FLAGS ? s2_flags.n : 1'b0;
  assign c      = REG_OUT_FLAGS ? s2_flags.c : 1'b0;

endmodule

// File: tb/tb_compare_pipe.sv
// Self-checking bench for compare_pipe: arithmetic reference model plus literal vectors.
module tb_compare_pipe;
  import cmp_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   cmp_fn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         z, v, n, c;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_emit = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   zvnc;
  } exp_t;

  exp_t exp_q[$];
  exp_t front;

  compare_pipe #(.WIDTH(W), .REG_OUT_FLAGS(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cmp_fn    (cmp_fn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .v         (v),
    .n         (n),
    .c         (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: signed/unsigned comparisons and range overflow on integers.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] fn);
    exp_t         e;
    longint       sa, sb, sd;
    logic [W-1:0] s;
    logic         eq, lt, ltu, ovf, cb;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    sd  = sa - sb;
    s   = ma - mb;
    eq  = (ma == mb);
    lt  = (sa < sb);
    ltu = (ma < mb);
    ovf = (sd > ((longint'(1) << (W-1)) - 1)) || (sd < -(longint'(1) << (W-1)));
    case (fn)
      2'b00:   cb = ltu;
      2'b01:   cb = eq;
      2'b10:   cb = lt;
      default: cb = lt | eq;
    endcase
    e.res    = '0;
    e.res[0] = cb;
    e.zvnc   = {eq, ovf, s[W-1], ~ltu};
    return e;
  endfunction

  // Compare process: every valid output beat is matched against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          front = exp_q[0];
          check("model_result", result, front.res);
          check("model_zvnc", {z, v, n, c}, front.zvnc);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_emit++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cmp_fn));
    end
  end

  task automatic run_beat(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [1:0] fn, input logic [W-1:0] eres, input logic [3:0] ezvnc);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_; cmp_fn = fn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({nm, "_latency"}, lat, 2);
    check({nm, "_result"}, result, eres);
    check({nm, "_zvnc"}, {z, v, n, c}, ezvnc);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check({nm, "_drained"}, exp_q.size(), 0);
  endtask

  logic [W-1:0] va[4] = '{16'h0005, 16'h0003, 16'h1234, 16'h7FFF};
  logic [W-1:0] vb[4] = '{16'h0003, 16'h0005, 16'h1234, 16'h8000};
  logic [1:0]   vf[4] = '{CMP_LTU, CMP_LTU, CMP_EQ, CMP_LT};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cmp_fn = CMP_LTU;

    // Reset state.
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zvnc", {z, v, n, c}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
    end

    // Directed vectors with hand-computed results and {z,v,n,c}.
    run_beat("lt_pos",      16'h0101, 16'h0011, CMP_LT,  16'h0000, 4'b0001);
    run_beat("lt_neg1",     16'hFFFF, 16'h0001, CMP_LT,  16'h0001, 4'b0011);
    run_beat("ltu_ffff",    16'hFFFF, 16'h0001, CMP_LTU, 16'h0000, 4'b0011);
    run_beat("eq_ffff",     16'hFFFF, 16'h0001, CMP_EQ,  16'h0000, 4'b0011);
    run_beat("le_negs",     16'hC0FF, 16'hEECC, CMP_LE,  16'h0001, 4'b0010);
    run_beat("lt_ovf",      16'h8000, 16'h0001, CMP_LT,  16'h0001, 4'b0101);
    run_beat("le_equal",    16'hA234, 16'hA234, CMP_LE,  16'h0001, 4'b1001);
    drain("directed");

    // Four back-to-back beats with out_ready low for three cycles.
    n_emit = 0;
    sent   = 0;
    for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = 1'b1;
      a = va[sent]; b = vb[sent]; cmp_fn = vf[sent];
      @(negedge clk);
      acc = in_ready;
      if (cyc == 2) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_result_c2", result, 16'h0000);
        check("stall_zvnc_c2", {z, v, n, c}, 4'b0001);
      end
      if (cyc == 3) begin
        check("stall_result_c3", result, 16'h0000);
        check("stall_zvnc_c3", {z, v, n, c}, 4'b0001);
      end
      if (acc) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain("stall");
    check("stall_accepted", sent, 4);
    check("stall_emitted", n_emit, 4);

    // Reset while both stages hold beats.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 16'h0001; b = 16'h0002; cmp_fn = CMP_LTU;
    @(posedge clk); #1;
    a = 16'h0009; b = 16'h0002; cmp_fn = CMP_EQ;
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0003; cmp_fn = CMP_EQ;
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    run_beat("post_rst", 16'h0002, 16'h0001, CMP_LTU, 16'h0000, 4'b0001);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
